memory_io_waitstate: RTL and testbench

Parametrised 8088-bus memory/IO slave: the next generation of the team's memory/IO module. It adds programmable wait states with a READY handshake, a read-only (ROM) mode, address-range qualification and an error flag. Writes are fully synchronous. It sits on the demultiplexed 8088 bus behind the address decoder that drives CS, and its READY output feeds the CPU READY-merge logic.

---
 rtl/memio_pkg.sv | 15 +
 rtl/memio_ram.sv | 35 +++
 rtl/memory_io_waitstate.sv | 147 ++++++++++++++
 tb/tb_memory_io_waitstate.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/memio_pkg.sv
// Shared types and limits for the 8088-bus memory/IO slave.
package memio_pkg;

    localparam int MAX_WAIT_STATES = 15;
    localparam int WAIT_CNT_WIDTH  = 4;

    // One-hot bus cycle state.
    typedef enum logic [3:0] {
        IDLE = 4'b0001,
        WAIT = 4'b0010,
        XFER = 4'b0100,
        HOLD = 4'b1000
    } State_t;

endpackage

// File: rtl/memio_ram.sv
// Storage array: synchronous write port, registered read port with enable.
module memio_ram #(
    parameter int    DATA_WIDTH  = 8,
    parameter int    NUM_UNITS   = 512 * 1024,
    parameter int    INDEX_WIDTH = 19,
    parameter string INIT_FILE   = ""
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   wr_en,
    input  logic [INDEX_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0]  wr_data,
    input  logic                   rd_en,
    input  logic [INDEX_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0]  rd_data
);

    logic [DATA_WIDTH-1:0] mem [0:NUM_UNITS-1];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Read register only updates on the edge entering XFER, so it holds through HOLD.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/memory_io_waitstate.sv
// 8088-bus memory/IO slave with programmable wait states, READY handshake,
// optional ROM mode, address-range qualification and a rejected-write flag.
module memory_io_waitstate
    import memio_pkg::*;
#(
    parameter int                    ADDR_WIDTH  = 20,
    parameter int                    DATA_WIDTH  = 8,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0,
    parameter int                    NUM_UNITS   = 512 * 1024,
    parameter int                    WAIT_STATES = 0,
    parameter bit                    READ_ONLY   = 1'b0,
    parameter string                 INIT_FILE   = ""
) (
    input  logic                  CLK,
    input  logic                  RESET_N,
    input  logic                  CS,
    input  logic                  RD,
    input  logic                  WR,
    input  logic [ADDR_WIDTH-1:0] ADDRESS,
    inout  wire  [DATA_WIDTH-1:0] DATA,
    output logic                  READY,
    output logic                  ERR
);

    localparam int INDEX_WIDTH = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1;
    localparam int EXT_WIDTH   = ADDR_WIDTH + 1;
    localparam logic [EXT_WIDTH-1:0] NUM_UNITS_EXT = EXT_WIDTH'(NUM_UNITS);
    localparam logic [WAIT_CNT_WIDTH-1:0] WAIT_LOAD =
        (WAIT_STATES > 0) ? WAIT_CNT_WIDTH'(WAIT_STATES - 1) : '0;

    if (WAIT_STATES < 0 || WAIT_STATES > MAX_WAIT_STATES) begin : g_bad_wait_states
        $error("memory_io_waitstate: WAIT_STATES must be within 0..15");
    end

    State_t                    state_reg;
    logic [WAIT_CNT_WIDTH-1:0] wait_cnt_reg;
    logic [INDEX_WIDTH-1:0]    idx_reg;
    logic                      is_write_reg;
    logic                      oe_reg;
    logic                      ready_reg;
    logic                      err_reg;

    logic [EXT_WIDTH-1:0]      offset;
    logic [INDEX_WIDTH-1:0]    index;
    logic                      in_range;
    logic                      start;
    logic                      strobe_held;
    logic                      wait_done;
    logic                      ram_rd_en;
    logic                      ram_wr_en;
    logic [INDEX_WIDTH-1:0]    ram_rd_addr;
    logic [DATA_WIDTH-1:0]     ram_rd_data;

    // One extra bit so an address below BASE_ADDR shows up as a borrow.
    assign offset   = {1'b0, ADDRESS} - {1'b0, BASE_ADDR};
    assign in_range = !offset[ADDR_WIDTH] && (offset < NUM_UNITS_EXT);
    assign index    = offset[INDEX_WIDTH-1:0];

    assign start       = CS && (RD ^ WR) && in_range;
    assign strobe_held = CS && (is_write_reg ? !WR : !RD);
    assign wait_done   = (wait_cnt_reg == '0);

    // Launch the RAM read on whichever edge moves the FSM into XFER.
    assign ram_rd_en   = ((state_reg == IDLE) && start && !RD && (WAIT_STATES == 0))
                      || ((state_reg == WAIT) && strobe_held && wait_done && !is_write_reg);
    assign ram_rd_addr = (state_reg == IDLE) ? index : idx_reg;
    assign ram_wr_en   = (state_reg == XFER) && is_write_reg && !READ_ONLY;

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_reg    <= IDLE;
            wait_cnt_reg <= '0;
            idx_reg      <= '0;
            is_write_reg <= 1'b0;
            oe_reg       <= 1'b0;
            ready_reg    <= 1'b1;
            err_reg      <= 1'b0;
        end else begin
            err_reg <= 1'b0;
            unique case (state_reg)
                IDLE: begin
                    if (start) begin
                        idx_reg      <= index;
                        is_write_reg <= !WR;
                        wait_cnt_reg <= WAIT_LOAD;
                        if (WAIT_STATES > 0) begin
                            state_reg <= WAIT;
                            ready_reg <= 1'b0;
                        end else begin
                            state_reg <= XFER;
                            oe_reg    <= !RD;
                            err_reg   <= !WR && READ_ONLY;
                        end
                    end
                end
                WAIT: begin
                    if (!strobe_held) begin
                        state_reg <= IDLE;
                        ready_reg <= 1'b1;
                    end else if (wait_done) begin
                        state_reg <= XFER;
                        ready_reg <= 1'b1;
                        oe_reg    <= !is_write_reg;
                        err_reg   <= is_write_reg && READ_ONLY;
                    end else begin
                        wait_cnt_reg <= wait_cnt_reg - WAIT_CNT_WIDTH'(1);
                    end
                end
                XFER: begin
                    state_reg <= HOLD;
                end
                HOLD: begin
                    if (!CS || (RD && WR)) begin
                        state_reg <= IDLE;
                        oe_reg    <= 1'b0;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    oe_reg    <= 1'b0;
                    ready_reg <= 1'b1;
                end
            endcase
        end
    end

    memio_ram #(
        .DATA_WIDTH  (DATA_WIDTH),
        .NUM_UNITS   (NUM_UNITS),
        .INDEX_WIDTH (INDEX_WIDTH),
        .INIT_FILE   (INIT_FILE)
    ) u_ram (
        .clk     (CLK),
        .rst_n   (RESET_N),
        .wr_en   (ram_wr_en),
        .wr_addr (idx_reg),
        .wr_data (DATA),
        .rd_en   (ram_rd_en),
        .rd_addr (ram_rd_addr),
        .rd_data (ram_rd_data)
    );

    assign DATA  = oe_reg ? ram_rd_data : 'z;
    assign READY = ready_reg;
    assign ERR   = err_reg;

endmodule

// File: tb/tb_memory_io_waitstate.sv
// Two slaves on one bus: unit A (3 wait states, read/write) and unit B (no waits, ROM),
// checked cycle by cycle against a transaction-level model of the bus protocol.
module tb_memory_io_waitstate;

    localparam int         AW     = 20;
    localparam int         DW     = 8;
    localparam int         NU     = 64;
    localparam int         WS_A   = 3;
    localparam logic [19:0] BASE_A = 20'h00100;
    localparam logic [19:0] BASE_B = 20'h00200;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cs = 1'b0;
    logic        rd = 1'b1;
    logic        wr = 1'b1;
    logic [19:0] addr = '0;
    logic        tb_oe = 1'b1;
    logic [7:0]  tb_drive = 8'h00;
    wire  [7:0]  data_bus;
    logic        ready_a, ready_b, err_a, err_b;

    // Bench drives a background value whenever no slave should, so a stray
    // slave drive corrupts the bus and shows up as a data mismatch.
    assign data_bus = tb_oe ? tb_drive : 8'hzz;

    always #5 clk = ~clk;

    memory_io_waitstate #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BASE_ADDR(BASE_A), .NUM_UNITS(NU),
        .WAIT_STATES(WS_A), .READ_ONLY(1'b0), .INIT_FILE("")
    ) dut_a (
        .CLK(clk), .RESET_N(rst_n), .CS(cs), .RD(rd), .WR(wr),
        .ADDRESS(addr), .DATA(data_bus), .READY(ready_a), .ERR(err_a)
    );

    memory_io_waitstate #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BASE_ADDR(BASE_B), .NUM_UNITS(NU),
        .WAIT_STATES(0), .READ_ONLY(1'b1), .INIT_FILE("")
    ) dut_b (
        .CLK(clk), .RESET_N(rst_n), .CS(cs), .RD(rd), .WR(wr),
        .ADDRESS(addr), .DATA(data_bus), .READY(ready_b), .ERR(err_b)
    );

    logic [7:0] model_a [NU];
    logic [7:0] model_b [NU];

    logic       chk_en = 1'b0;
    logic       exp_ready_a = 1'b1, exp_ready_b = 1'b1;
    logic       exp_err_a = 1'b0, exp_err_b = 1'b0;
    logic       exp_drv = 1'b0;
    logic [7:0] exp_data = 8'h00;
    logic [7:0] last_read = 8'h00;
    int         total = 0;
    int         bad = 0;
    int         ready_a_low = 0;
    int         err_b_pulses = 0;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set_idle_exp();
        exp_ready_a = 1'b1;
        exp_ready_b = 1'b1;
        exp_err_a   = 1'b0;
        exp_err_b   = 1'b0;
        exp_drv     = 1'b0;
        tb_oe       = 1'b1;
        exp_data    = tb_drive;
    endtask

    // Per-cycle compare against the model's expectations.
    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                check("ready_a", {7'b0, ready_a}, {7'b0, exp_ready_a});
                check("ready_b", {7'b0, ready_b}, {7'b0, exp_ready_b});
                check("err_a", {7'b0, err_a}, {7'b0, exp_err_a});
                check("err_b", {7'b0, err_b}, {7'b0, exp_err_b});
                check("data", data_bus, exp_data);
                if (exp_drv) last_read = data_bus;
                if (ready_a === 1'b0) ready_a_low++;
                if (err_b === 1'b1) err_b_pulses++;
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            cs = 1'b0; rd = 1'b1; wr = 1'b1;
            tb_drive = 8'($urandom);
            set_idle_exp();
        end
    endtask

    // unit: 0=A, 1=B, 2=neither. Strobe (or CS if rel_cs) released during cycle rel,
    // cycles counted from 1 after the start edge. rst_at>0 pulses reset in that cycle.
    task automatic access(input int unit, input logic [19:0] a, input bit is_wr,
                          input logic [7:0] wd, input int rel, input bit rel_cs,
                          input bit both, input int rst_at);
        int w;
        bit start;
        bit rom;
        bit drv;
        int idx;
        logic [7:0] rv;
        w     = (unit == 0) ? WS_A : 0;
        rom   = (unit == 1);
        start = (unit < 2) && !both;
        idx   = (unit == 0) ? int'(a - BASE_A) : ((unit == 1) ? int'(a - BASE_B) : 0);
        rv    = (unit == 0) ? model_a[idx] : model_b[idx];
        @(posedge clk);
        #1;
        cs = 1'b1; addr = a;
        rd = both ? 1'b0 : is_wr;
        wr = both ? 1'b0 : !is_wr;
        tb_drive = is_wr ? wd : 8'($urandom);
        set_idle_exp();
        for (int c = 1; c <= rel; c++) begin
            @(posedge clk);
            if (start && is_wr && !rom && c == w + 2) model_a[idx] = wd;
            #1;
            if (c == rel) begin
                if (rel_cs) cs = 1'b0;
                else begin rd = 1'b1; wr = 1'b1; end
            end
            drv = start && !is_wr && (c >= w + 1);
            exp_ready_a = !(start && unit == 0 && c <= w);
            exp_ready_b = !(start && unit == 1 && c <= w);
            exp_err_a   = 1'b0;
            exp_err_b   = start && rom && is_wr && (c == w + 1);
            exp_drv     = drv;
            tb_oe       = !drv;
            exp_data    = drv ? rv : tb_drive;
            if (c == rst_at) begin
                #1;
                rst_n = 1'b0;
                tb_oe = 1'b1;
                #1;
                check("rst_ready_a", {7'b0, ready_a}, 8'h01);
                check("rst_err", {6'b0, err_a, err_b}, 8'h00);
                check("rst_data", data_bus, tb_drive);
                cs = 1'b0; rd = 1'b1; wr = 1'b1;
                rst_n = 1'b1;
                set_idle_exp();
                break;
            end
        end
    endtask

    initial begin
        int unit, rel, kind, idx, snap;
        logic [19:0] a;
        bit is_wr, rel_cs, both;
        logic [7:0] wd;

        for (int i = 0; i < NU; i++) begin
            model_a[i] = 8'(i * 7 + 3);
            model_b[i] = 8'(i) ^ 8'hC3;
        end
        model_a[0]  = 8'h3C;
        model_a[1]  = 8'h81;
        model_a[2]  = 8'h42;
        model_a[32] = 8'h5A;
        model_b[5]  = 8'h11;
        for (int i = 0; i < NU; i++) begin
            dut_a.u_ram.mem[i] = model_a[i];
            dut_b.u_ram.mem[i] = model_b[i];
        end

        set_idle_exp();
        chk_en = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(2);

        // Preloaded read with wait states: READY low exactly WS_A cycles.
        snap = ready_a_low;
        access(0, BASE_A, 1'b0, 8'h00, WS_A + 2, 1'b0, 1'b0, 0);
        check("lit_read_3c", last_read, 8'h3C);
        check("lit_ready_low", 8'(ready_a_low - snap), 8'd3);

        // Write then read back.
        access(0, BASE_A + 20'h10, 1'b1, 8'hA5, WS_A + 2, 1'b0, 1'b0, 0);
        access(0, BASE_A + 20'h10, 1'b0, 8'h00, WS_A + 2, 1'b0, 1'b0, 0);
        check("lit_read_a5", last_read, 8'hA5);
        idle(1);

        // ROM write rejected with one ERR pulse; contents unchanged.
        snap = err_b_pulses;
        access(1, BASE_B + 20'd5, 1'b1, 8'hFF, 3, 1'b0, 1'b0, 0);
        check("lit_err_pulses", 8'(err_b_pulses - snap), 8'd1);
        access(1, BASE_B + 20'd5, 1'b0, 8'h00, 2, 1'b0, 1'b0, 0);
        check("lit_rom_11", last_read, 8'h11);
        idle(1);

        // Out-of-range just past unit A, and both strobes low: ignored.
        access(2, BASE_A + 20'(NU), 1'b0, 8'h00, 3, 1'b0, 1'b0, 0);
        idle(1);
        access(0, BASE_A + 20'd3, 1'b0, 8'h00, 4, 1'b0, 1'b1, 0);
        idle(1);

        // Write aborted in the 2nd wait cycle leaves memory unchanged.
        access(0, BASE_A + 20'd32, 1'b1, 8'h77, 2, 1'b0, 1'b0, 0);
        access(0, BASE_A + 20'd32, 1'b0, 8'h00, WS_A + 2, 1'b0, 1'b0, 0);
        check("lit_abort_5a", last_read, 8'h5A);
        idle(1);

        // Reset pulsed in the XFER cycle of a read.
        access(0, BASE_A + 20'd2, 1'b0, 8'h00, WS_A + 4, 1'b0, 1'b0, WS_A + 1);
        idle(2);

        // Back-to-back reads with a one-cycle strobe release.
        access(0, BASE_A + 20'd1, 1'b0, 8'h00, WS_A + 2, 1'b0, 1'b0, 0);
        check("lit_b2b_81", last_read, 8'h81);
        access(0, BASE_A + 20'd2, 1'b0, 8'h00, WS_A + 2, 1'b0, 1'b0, 0);
        check("lit_b2b_42", last_read, 8'h42);
        idle(1);

        for (int t = 0; t < 200; t++) begin
            kind   = int'($urandom_range(0, 9));
            is_wr  = 1'($urandom_range(0, 1));
            wd     = 8'($urandom);
            rel_cs = ($urandom_range(0, 3) == 0);
            both   = (kind == 3);
            if (kind <= 4) begin
                unit = 0;
                idx  = int'($urandom_range(0, NU - 1));
                a    = BASE_A + 20'(idx);
                rel  = (kind == 4) ? int'($urandom_range(1, WS_A))
                                   : int'($urandom_range(WS_A + 2, WS_A + 4));
            end else if (kind <= 7) begin
                unit = 1;
                idx  = int'($urandom_range(0, NU - 1));
                a    = BASE_B + 20'(idx);
                rel  = int'($urandom_range(2, 4));
            end else begin
                unit = 2;
                case ($urandom_range(0, 3))
                    0:       a = BASE_A - 20'd1;
                    1:       a = BASE_A + 20'(NU);
                    2:       a = BASE_B + 20'(NU);
                    default: a = {1'b1, 19'($urandom)};
                endcase
                rel = int'($urandom_range(1, 3));
            end
            access(unit, a, is_wr, wd, rel, rel_cs, both, 0);
            if ($urandom_range(0, 2) == 0) idle(1);
        end
        idle(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
        $fatal(1, "watchdog");
    end

endmodule
